// File: rtl/control_unit_pkg.sv
// Shared types and constants for the instruction-sequencing control unit.
package control_unit_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_ROR  = 5'b00101;
  localparam logic [4:0] OP_ROL  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_INC_PC = 5'b11111;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_ROR, OP_ROL, OP_SHL, OP_SHRA:     return CLS_ALU;
      OP_MUL, OP_DIV:                      return CLS_MULDIV;
      OP_NOP:                              return CLS_NOP;
      OP_HALT:                             return CLS_HALT;
      default:                             return CLS_ILLEGAL;
    endcase
  endfunction

  // ALU_CODE table: opcode -> ALU operation select
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return 5'b00011;
      OP_SUB:  return 5'b00100;
      OP_AND:  return 5'b00101;
      OP_OR:   return 5'b00110;
      OP_SHR:  return 5'b00111;
      OP_ROR:  return 5'b01000;
      OP_ROL:  return 5'b01001;
      OP_SHL:  return 5'b01010;
      OP_SHRA: return 5'b01011;
      OP_MUL:  return 5'b01111;
      OP_DIV:  return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_reg_decoder.sv
// 4-bit register field to one-hot 16-bit select; all zero when disabled.
module reg_decoder (
  input  logic [3:0]  sel_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  assign onehot_o = en_i ? (16'h0001 << sel_i) : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// Fetch/execute sequencer driving datapath strobes from the current state.
// state | meaning
// IDLE  | waiting for run
// T0    | PC to MAR, Z <= PC+1
// T1    | PC <= Z, memory read, wait for mem_ready
// T2    | MDR to IR
// T3    | Y <= R[Rb], opcode dispatch
// T4    | Z <= Y op R[Rc]
// T5    | R[Ra] or LO <= ZLO
// T6    | HI <= ZHI
// HALT  | stopped until clr
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        Pout,
  output logic        MARen,
  output logic        Pen,
  output logic        Read,
  output logic        MDRen,
  output logic        MDROut,
  output logic        IRen,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZHIen,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIen,
  output logic        LOen,
  output logic [15:0] Rout,
  output logic [15:0] Ren,
  output logic [4:0]  alu_control,
  output logic        halted,
  output logic        illegal
);

  state_e     state_q, state_d;
  logic [4:0] alu_q, alu_d;
  op_class_e  cls;
  logic       is_exec;
  logic       rout_en, ren_en;
  logic [3:0] rout_sel;
  logic       ir_unused;

  assign cls       = op_class(ir[31:27]);
  assign is_exec   = (cls == CLS_ALU) || (cls == CLS_MULDIV);
  assign ir_unused = ^ir[14:0];

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    case (state_q)
      IDLE: if (run) begin
        state_d = T0;
        alu_d   = ALU_INC_PC;
      end
      T0:   state_d = T1;
      T1:   if (mem_ready) state_d = T2;
      T2:   state_d = T3;
      T3: begin
        if (is_exec) begin
          state_d = T4;
          alu_d   = alu_code(ir[31:27]);
        end else if (cls == CLS_HALT) begin
          state_d = HALT;
        end else begin
          state_d = IDLE;
        end
      end
      T4:   state_d = T5;
      T5:   state_d = (cls == CLS_MULDIV) ? T6 : IDLE;
      T6:   state_d = IDLE;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // alu_control is registered on entry to T0/T4 so it holds between them
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      alu_q   <= 5'b00000;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
    end
  end

  always_comb begin
    Pout = 1'b0; MARen = 1'b0; Pen = 1'b0; Read = 1'b0; MDRen = 1'b0;
    MDROut = 1'b0; IRen = 1'b0; Yen = 1'b0; ZLOen = 1'b0; ZHIen = 1'b0;
    ZLOout = 1'b0; ZHIout = 1'b0; HIen = 1'b0; LOen = 1'b0;
    halted = 1'b0; illegal = 1'b0;
    rout_en = 1'b0; rout_sel = 4'd0; ren_en = 1'b0;
    case (state_q)
      T0: begin Pout = 1'b1; MARen = 1'b1; ZLOen = 1'b1; end
      T1: begin
        ZLOout = 1'b1; Read = 1'b1; MDRen = 1'b1;
        Pen    = mem_ready;
      end
      T2: begin MDROut = 1'b1; IRen = 1'b1; end
      T3: begin
        rout_en  = is_exec;
        rout_sel = ir[22:19];
        Yen      = is_exec;
        illegal  = (cls == CLS_ILLEGAL);
      end
      T4: begin
        rout_en  = 1'b1;
        rout_sel = ir[18:15];
        ZLOen    = 1'b1;
        ZHIen    = (cls == CLS_MULDIV);
      end
      T5: begin
        ZLOout = 1'b1;
        LOen   = (cls == CLS_MULDIV);
        ren_en = (cls != CLS_MULDIV);
      end
      T6:   begin ZHIout = 1'b1; HIen = 1'b1; end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign alu_control = alu_q;

  reg_decoder u_rout_dec (
    .sel_i    (rout_sel),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

  reg_decoder u_ren_dec (
    .sel_i    (ir[26:23]),
    .en_i     (ren_en),
    .onehot_o (Ren)
  );

endmodule
